mouse_master_ctrl: RTL and testbench

Parametrised PS/2 mouse host controller. It is the successor to the current mouse master state machine and sits between the PS/2 transmitter/receiver pair and the bus-side mouse peripheral registers. It adds full reset/BAT checking, ack timeouts with bounded retries, optional IntelliMouse wheel negotiation (3- or 4-byte packets), packet sync checking, and a held interrupt with processor acknowledge.

---
 rtl/mouse_master_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mouse_master_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_master_ctrl.sv
// PS/2 mouse host: reset/BAT check, optional wheel negotiation, packet capture with held interrupt.
// Outputs update the cycle after the last packet byte; a command waits for BYTE_SENT and its reply.
module mouse_master_ctrl #(
  parameter int TICKS_PER_MS    = 50000,
  parameter int ACK_TIMEOUT_MS  = 20,
  parameter int BAT_TIMEOUT_MS  = 500,
  parameter int IDLE_TIMEOUT_MS = 20000,
  parameter int WHEEL_EN        = 1,
  parameter int MAX_RETRY       = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic [7:0] MOUSE_DZ,
  output logic       SEND_INTERRUPT,
  input  logic       INTERRUPT_ACK,
  output logic       WHEEL_ACTIVE,
  output logic       INIT_FAIL,
  output logic [3:0] CURRENT_STATE
);

  typedef enum logic [3:0] {
    RST_TX  = 4'd0,
    RST_ACK = 4'd1,
    BAT     = 4'd2,
    BAT_ID  = 4'd3,
    CMD_TX  = 4'd4,
    CMD_ACK = 4'd5,
    ID_RD   = 4'd6,
    STREAM  = 4'd7,
    FAIL    = 4'd8
  } state_t;

  localparam int NCMD = (WHEEL_EN != 0) ? 8 : 1;

  state_t      state, state_nxt;
  logic [31:0] tick_cnt, ms_cnt, ms_limit;
  logic        ms_tick, timeout;
  logic [2:0]  cmd_idx;
  logic [7:0]  cur_cmd, retry_cnt;
  logic        need_send, send_now;
  logic        rx_good, rx_bad, fail_evt, resend, idx_inc;
  logic [1:0]  pkt_idx;
  logic [7:0]  sh0, sh1, sh2;
  logic        pkt_take, pkt_last, pkt_done;

  // Sample-rate (F3 C8/64/50) knock sequence, then ID query, then enable streaming.
  function automatic logic [7:0] cmd_byte(input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0, 3'd2, 3'd4: b = 8'hF3;
      3'd1:             b = 8'hC8;
      3'd3:             b = 8'h64;
      3'd5:             b = 8'h50;
      3'd6:             b = 8'hF2;
      default:          b = 8'hF4;
    endcase
    if (WHEEL_EN == 0) b = 8'hF4;
    return b;
  endfunction

  assign ms_tick       = (tick_cnt == 32'(TICKS_PER_MS - 1));
  assign rx_good       = BYTE_READY && (BYTE_ERROR_CODE == 2'd0);
  assign rx_bad        = BYTE_READY && (BYTE_ERROR_CODE != 2'd0);
  assign cur_cmd       = cmd_byte(cmd_idx);
  assign send_now      = need_send && ((state == RST_TX) || (state == CMD_TX));
  assign timeout       = !BYTE_READY && (ms_cnt == ms_limit);
  assign CURRENT_STATE = state;

  assign pkt_last = WHEEL_ACTIVE ? (pkt_idx == 2'd3) : (pkt_idx == 2'd2);
  assign pkt_take = (state == STREAM) && rx_good && ((pkt_idx != 2'd0) || BYTE_READ[3]);
  assign pkt_done = pkt_take && pkt_last;

  always_comb begin
    ms_limit = 32'(ACK_TIMEOUT_MS);
    if (state == BAT)         ms_limit = 32'(BAT_TIMEOUT_MS);
    else if (state == STREAM) ms_limit = 32'(IDLE_TIMEOUT_MS);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= RST_TX;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fail_evt  = 1'b0;
    resend    = 1'b0;
    idx_inc   = 1'b0;
    case (state)
      RST_TX:  if (BYTE_SENT) state_nxt = RST_ACK;
      RST_ACK: if (rx_good && BYTE_READ == 8'hFA) state_nxt = BAT;
               else if (BYTE_READY || timeout) fail_evt = 1'b1;
      BAT:     if (rx_good && BYTE_READ == 8'hAA) state_nxt = BAT_ID;
               else if (BYTE_READY || timeout) fail_evt = 1'b1;
      BAT_ID:  if (rx_good && BYTE_READ == 8'h00) state_nxt = CMD_TX;
               else if (BYTE_READY || timeout) fail_evt = 1'b1;
      CMD_TX:  if (BYTE_SENT) state_nxt = CMD_ACK;
      CMD_ACK: begin
        if (rx_good && BYTE_READ == 8'hFA) begin
          if (cur_cmd == 8'hF2)                  state_nxt = ID_RD;
          else if (cmd_idx == 3'(NCMD - 1))      state_nxt = STREAM;
          else begin
            idx_inc   = 1'b1;
            state_nxt = CMD_TX;
          end
        end else if (rx_good && BYTE_READ == 8'hFE) begin
          resend = 1'b1;
        end else if (BYTE_READY || timeout) begin
          fail_evt = 1'b1;
        end
      end
      ID_RD: begin
        if (rx_good) begin
          idx_inc   = 1'b1;
          state_nxt = CMD_TX;
        end else if (BYTE_READY || timeout) begin
          fail_evt = 1'b1;
        end
      end
      STREAM:  if (timeout) state_nxt = RST_TX;
      FAIL:    state_nxt = FAIL;
      default: state_nxt = RST_TX;
    endcase
    // A resend consumes the same retry budget as a full re-initialisation.
    if (fail_evt || resend) begin
      if (retry_cnt >= 8'(MAX_RETRY - 1)) state_nxt = FAIL;
      else if (resend)                    state_nxt = CMD_TX;
      else                                state_nxt = RST_TX;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tick_cnt       <= 32'd0;
      ms_cnt         <= 32'd0;
      cmd_idx        <= 3'd0;
      retry_cnt      <= 8'd0;
      need_send      <= 1'b1;
      SEND_BYTE      <= 1'b0;
      BYTE_TO_SEND   <= 8'hFF;
      READ_ENABLE    <= 1'b0;
      WHEEL_ACTIVE   <= 1'b0;
      INIT_FAIL      <= 1'b0;
      pkt_idx        <= 2'd0;
      sh0            <= 8'h00;
      sh1            <= 8'h00;
      sh2            <= 8'h00;
      MOUSE_STATUS   <= 8'h00;
      MOUSE_DX       <= 8'h00;
      MOUSE_DY       <= 8'h00;
      MOUSE_DZ       <= 8'h00;
      SEND_INTERRUPT <= 1'b0;
    end else begin
      tick_cnt <= ms_tick ? 32'd0 : tick_cnt + 32'd1;
      if ((state_nxt != state) || BYTE_READY) ms_cnt <= 32'd0;
      else if (ms_tick)                       ms_cnt <= ms_cnt + 32'd1;

      SEND_BYTE <= send_now;
      if (send_now) begin
        BYTE_TO_SEND <= (state == RST_TX) ? 8'hFF : cur_cmd;
        need_send    <= 1'b0;
      end
      if ((state_nxt != state) && ((state_nxt == RST_TX) || (state_nxt == CMD_TX)))
        need_send <= 1'b1;
      READ_ENABLE <= !((state == RST_TX) || (state == CMD_TX) || (state == FAIL));

      if (state_nxt == RST_TX) cmd_idx <= 3'd0;
      else if (idx_inc)        cmd_idx <= cmd_idx + 3'd1;

      if ((state_nxt == STREAM) && (state != STREAM)) retry_cnt <= 8'd0;
      else if (fail_evt || resend)                    retry_cnt <= retry_cnt + 8'd1;

      if ((state_nxt == RST_TX) && (state != RST_TX)) WHEEL_ACTIVE <= 1'b0;
      else if ((state == ID_RD) && rx_good)           WHEEL_ACTIVE <= (BYTE_READ == 8'h03);
      if (state_nxt == FAIL) INIT_FAIL <= 1'b1;

      // The final byte bypasses the shadow so outputs land one cycle after it.
      if ((state != STREAM) || rx_bad) begin
        pkt_idx <= 2'd0;
      end else if (pkt_take) begin
        case (pkt_idx)
          2'd0:    sh0 <= BYTE_READ;
          2'd1:    sh1 <= BYTE_READ;
          default: sh2 <= BYTE_READ;
        endcase
        pkt_idx <= pkt_last ? 2'd0 : pkt_idx + 2'd1;
      end
      if (pkt_done) begin
        MOUSE_STATUS <= sh0;
        MOUSE_DX     <= sh1;
        MOUSE_DY     <= WHEEL_ACTIVE ? sh2 : BYTE_READ;
        MOUSE_DZ     <= WHEEL_ACTIVE ? BYTE_READ : 8'h00;
      end

      if (pkt_done)           SEND_INTERRUPT <= 1'b1;
      else if (INTERRUPT_ACK) SEND_INTERRUPT <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mouse_master_ctrl.sv
// Directed bench for mouse_master_ctrl: PS/2 device replies driven from one sequence,
// expected command bytes and packets queued as stimulus is issued and compared on DUT output.
module tb_mouse_master_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       BYTE_SENT = 1'b0;
  logic       BYTE_READY = 1'b0;
  logic       INTERRUPT_ACK = 1'b0;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'd0;
  logic       SEND_BYTE, READ_ENABLE, SEND_INTERRUPT, WHEEL_ACTIVE, INIT_FAIL;
  logic [7:0] BYTE_TO_SEND, MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ;
  logic [3:0] CURRENT_STATE;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [7:0] dz;
  } pkt_t;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         send_cnt = 0;
  int         last_send_cyc = 0;
  int         gap = 0;
  int         cnt_before;
  pkt_t       pkt_q[$];
  pkt_t       last_pkt = '0;
  logic [7:0] exp_tx_q[$];

  mouse_master_ctrl #(
    .TICKS_PER_MS(50), .ACK_TIMEOUT_MS(20), .BAT_TIMEOUT_MS(50),
    .IDLE_TIMEOUT_MS(40), .WHEEL_EN(1), .MAX_RETRY(3)
  ) dut (
    .CLK(CLK), .RESET(RESET), .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
    .BYTE_SENT(BYTE_SENT), .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
    .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY),
    .MOUSE_DZ(MOUSE_DZ), .SEND_INTERRUPT(SEND_INTERRUPT), .INTERRUPT_ACK(INTERRUPT_ACK),
    .WHEEL_ACTIVE(WHEEL_ACTIVE), .INIT_FAIL(INIT_FAIL), .CURRENT_STATE(CURRENT_STATE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (SEND_BYTE) send_cnt <= send_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_send"}, 32'(SEND_BYTE), 32'd0);
    chk({tag, "_byte"}, 32'(BYTE_TO_SEND), 32'hFF);
    chk({tag, "_rden"}, 32'(READ_ENABLE), 32'd0);
    chk({tag, "_pkt"}, {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ}, 32'd0);
    chk({tag, "_int"}, 32'(SEND_INTERRUPT), 32'd0);
    chk({tag, "_wheel"}, 32'(WHEEL_ACTIVE), 32'd0);
    chk({tag, "_fail"}, 32'(INIT_FAIL), 32'd0);
    chk({tag, "_state"}, 32'(CURRENT_STATE), 32'd0);
  endtask

  // Waits for the next SEND_BYTE pulse, compares it against the queued byte, then plays the transmitter.
  task automatic expect_tx(input string tag, input int bound);
    logic [7:0] exp;
    bit seen;
    exp  = exp_tx_q.pop_front();
    seen = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge CLK);
      if (SEND_BYTE) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_byte"}, 32'(BYTE_TO_SEND), 32'(exp));
    chk({tag, "_rden"}, 32'(READ_ENABLE), 32'd0);
    gap = cyc - last_send_cyc;
    last_send_cyc = cyc;
    @(negedge CLK);
    chk({tag, "_pulse1"}, 32'(SEND_BYTE), 32'd0);
    repeat (2) @(posedge CLK);
    #1 BYTE_SENT = 1'b1;
    @(posedge CLK);
    #1 BYTE_SENT = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic [1:0] err, input bit ack);
    @(posedge CLK);
    #1;
    BYTE_READ = b;
    BYTE_ERROR_CODE = err;
    BYTE_READY = 1'b1;
    INTERRUPT_ACK = ack;
    @(posedge CLK);
    #1;
    BYTE_READY = 1'b0;
    INTERRUPT_ACK = 1'b0;
    BYTE_ERROR_CODE = 2'd0;
  endtask

  task automatic pulse_ack();
    @(posedge CLK);
    #1 INTERRUPT_ACK = 1'b1;
    @(posedge CLK);
    #1 INTERRUPT_ACK = 1'b0;
  endtask

  task automatic check_pkt(input string tag);
    pkt_t e;
    @(negedge CLK);
    e = pkt_q.pop_front();
    chk({tag, "_status"}, 32'(MOUSE_STATUS), 32'(e.st));
    chk({tag, "_dx"}, 32'(MOUSE_DX), 32'(e.dx));
    chk({tag, "_dy"}, 32'(MOUSE_DY), 32'(e.dy));
    chk({tag, "_dz"}, 32'(MOUSE_DZ), 32'(e.dz));
    last_pkt = e;
  endtask

  // Device side of initialisation after the 0xFF has been accepted.
  task automatic run_init(input logic [7:0] id, input bit fe_on_c8);
    logic [7:0] cmds [8] = '{8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
    send_rx(8'hFA, 2'd0, 1'b0);
    send_rx(8'hAA, 2'd0, 1'b0);
    send_rx(8'h00, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_tx_q.push_back(cmds[i]);
      expect_tx($sformatf("cmd%0d", i), 50);
      if (fe_on_c8 && i == 1) begin
        send_rx(8'hFE, 2'd0, 1'b0);
        exp_tx_q.push_back(cmds[i]);
        expect_tx("resend_c8", 50);
      end
      send_rx(8'hFA, 2'd0, 1'b0);
      if (i == 6) send_rx(id, 2'd0, 1'b0);
    end
    repeat (2) @(negedge CLK);
    chk("init_state", 32'(CURRENT_STATE), 32'd7);
    chk("init_rden", 32'(READ_ENABLE), 32'd1);
    chk("init_wheel", 32'(WHEEL_ACTIVE), 32'(id == 8'h03));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk_reset("por");
    @(posedge CLK);
    #1 RESET = 1'b1;

    // Wheel negotiation, device answers ID 0x03.
    exp_tx_q.push_back(8'hFF);
    expect_tx("a_ff", 20);
    run_init(8'h03, 1'b0);

    // 4-byte packets, held interrupt, set-beats-ack, error drop and resync.
    pkt_q.push_back('{8'h09, 8'h05, 8'hFB, 8'h01});
    send_rx(8'h09, 2'd0, 1'b0);
    send_rx(8'h05, 2'd0, 1'b0);
    send_rx(8'hFB, 2'd0, 1'b0);
    send_rx(8'h01, 2'd0, 1'b0);
    check_pkt("b_pkt1");
    chk("b_int_set", 32'(SEND_INTERRUPT), 32'd1);
    repeat (5) @(negedge CLK);
    chk("b_int_held", 32'(SEND_INTERRUPT), 32'd1);
    pkt_q.push_back('{8'h18, 8'h01, 8'h02, 8'hFF});
    send_rx(8'h18, 2'd0, 1'b0);
    send_rx(8'h01, 2'd0, 1'b0);
    send_rx(8'h02, 2'd0, 1'b0);
    send_rx(8'hFF, 2'd0, 1'b1);
    check_pkt("b_pkt2");
    chk("b_int_setwins", 32'(SEND_INTERRUPT), 32'd1);
    pulse_ack();
    @(negedge CLK);
    chk("b_int_ack", 32'(SEND_INTERRUPT), 32'd0);
    send_rx(8'h09, 2'd0, 1'b0);
    send_rx(8'h11, 2'd1, 1'b0);
    send_rx(8'h22, 2'd0, 1'b0);
    @(negedge CLK);
    chk("b_err_noint", 32'(SEND_INTERRUPT), 32'd0);
    chk("b_err_keep", 32'(MOUSE_STATUS), 32'(last_pkt.st));
    pkt_q.push_back('{8'h0C, 8'h01, 8'h02, 8'h03});
    send_rx(8'h0C, 2'd0, 1'b0);
    send_rx(8'h01, 2'd0, 1'b0);
    send_rx(8'h02, 2'd0, 1'b0);
    send_rx(8'h03, 2'd0, 1'b0);
    check_pkt("b_pkt3");
    chk("b_int3", 32'(SEND_INTERRUPT), 32'd1);
    pulse_ack();

    // Idle timeout forces re-init, keeping packet registers.
    exp_tx_q.push_back(8'hFF);
    expect_tx("c_idle_ff", 2500);
    chk("c_wheel_clr", 32'(WHEEL_ACTIVE), 32'd0);
    chk("c_dx_keep", 32'(MOUSE_DX), 32'(last_pkt.dx));
    chk("c_dy_keep", 32'(MOUSE_DY), 32'(last_pkt.dy));

    // Plain mouse ID with a resend on C8, then a 3-byte packet after a resync byte.
    run_init(8'h00, 1'b1);
    pkt_q.push_back('{8'h08, 8'h10, 8'h20, 8'h00});
    send_rx(8'h00, 2'd0, 1'b0);
    send_rx(8'h08, 2'd0, 1'b0);
    send_rx(8'h10, 2'd0, 1'b0);
    @(negedge CLK);
    chk("d_int_early", 32'(SEND_INTERRUPT), 32'd0);
    send_rx(8'h20, 2'd0, 1'b0);
    check_pkt("d_pkt");
    chk("d_int", 32'(SEND_INTERRUPT), 32'd1);
    pulse_ack();

    // Reset in the middle of a packet.
    send_rx(8'h08, 2'd0, 1'b0);
    send_rx(8'h33, 2'd0, 1'b0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk_reset("e_rst");
    @(posedge CLK);
    #1 RESET = 1'b1;

    // Silent device: three 0xFF attempts one ack-timeout apart, then FAIL.
    exp_tx_q.push_back(8'hFF);
    expect_tx("f_ff1", 20);
    for (int k = 2; k <= 3; k++) begin
      exp_tx_q.push_back(8'hFF);
      expect_tx($sformatf("f_ff%0d", k), 1200);
      chk($sformatf("f_gap%0d", k), 32'((gap >= 900) && (gap <= 1100)), 32'd1);
    end
    cnt_before = send_cnt;
    repeat (1200) @(posedge CLK);
    @(negedge CLK);
    chk("f_init_fail", 32'(INIT_FAIL), 32'd1);
    chk("f_state", 32'(CURRENT_STATE), 32'd8);
    chk("f_rden", 32'(READ_ENABLE), 32'd0);
    chk("f_no_send", 32'(send_cnt - cnt_before), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
